huffman_decoder: RTL and testbench
==================================

// Module: huffman_decoder
// PURPOSE
//  Receive-side counterpart of the 6-symbol huffman encoder.
//  - Loads the code table (HC1..6 / M1..6) with the encoder's code_valid pulse.
//  - Decodes a serial MSB-first bitstream back into gray symbols 1..6.
//  - Sits downstream of the encoder in the loopback/contest environment; output feeds the symbol checker.
// PARAMETERS
//  W        8    width of HC/M entries, accumulator and sym_data
//  MAX_LEN  8    code length (bits) at which a non-matching prefix is declared an error; must be <= W
// PORTS
//  clk         in   1  rising-edge clock
//  reset       in   1  synchronous, active-high reset
//  code_valid  in   1  1-cycle pulse: HC1..6/M1..6 valid, load table
//  HC1..HC6    in   W  code of symbol k, right-aligned
//  M1..M6      in   W  mask of symbol k: (1<<len_k)-1
//  bit_valid   in   1  bit_data valid this cycle
//  bit_data    in   1  next code bit, MSB of each code first
//  ready       out  1  table loaded and no error (state RUN)
//  sym_valid   out  1  1-cycle pulse: sym_data holds a decoded symbol
//  sym_data    out  W  decoded symbol index 1..6
//  sym_cnt     out  8  symbols decoded since last table load; saturates at 255
//  err         out  1  sticky decode/table error
// BEHAVIOUR
//  - Reset values: ready=0, sym_valid=0, sym_data=0, sym_cnt=0, err=0; state=EMPTY; acc=0, len=0.
//  - States:
//      EMPTY: no table; bits ignored.
//      RUN:   decoding.
//      ERR:   bits ignored; err=1.
//  - code_valid, any state: latch all 12 entries, clear acc/len/sym_cnt/err.
//      Next state RUN if every M_k is in {01,03,07,0F,1F,3F,7F}, else ERR.
//  - code_valid and bit_valid in the same cycle: load wins; the bit is dropped.
//  - RUN, bit_valid=1:
//      nacc = {acc[W-2:0], bit_data}; nlen = len+1.
//      Match k when M_k == (1<<nlen)-1 and (nacc & M_k) == HC_k.
//  - On match:
//      Next cycle sym_valid=1 and sym_data=k (registered, latency 1 cycle after the edge sampling the last bit).
//      acc=0, len=0, sym_cnt+1 (saturating).
//      Multiple matches (duplicate entries): lowest k wins.
//  - No match:
//      acc=nacc, len=nlen.
//      If nlen==MAX_LEN, go to ERR with err=1 next cycle and no sym_valid.
//  - bit_valid=0: hold acc/len; gaps of any length are legal mid-code.
//  - sym_valid is low in every cycle not following a match; sym_data holds its last value.
//  - ready = (state==RUN).
//  - reset mid-code: everything, including the table, returns to the reset state; a new code_valid is required.
// STRUCTURE
//  - Shared package huffman_pkg:
//      NUM_SYM=6, W=8;
//      state encoding EMPTY/RUN/ERR;
//      function len_mask(n) = (1<<n)-1;
//      function is_mask(m).
//  - Sub-module huffman_code_match: combinational, one instance per symbol.
//      In:  HC_k, M_k, nacc, nlen.  Out: hit.
//      The top level priority-encodes the 6 hits.
//  - Top level holds the table regs, acc/len, FSM and output regs.
// TESTING
//  Table T for all scenarios:
//    HC = 00,02,06,0E,1E,1F; M = 01,03,07,0F,1F,1F (codes 0,10,110,1110,11110,11111).
//  1. Load T, bits 0,1,0,1,1,1,1,1
//       -> sym_valid pulses with sym_data 1,2,6, each 1 cycle after its last bit; sym_cnt=3; ready=1.
//  2. Load T, bits 1,1 then bit_valid=0 for 5 cycles, then 0
//       -> single symbol 3 after the final bit; no pulse during the gap.
//  3. Load T with M3=05
//       -> ready=0, err=1; subsequent bits produce no sym_valid.
//  4. Load T with HC6=1E (duplicate of symbol 5), bits 1,1,1,1,0
//       -> sym_data=5 (lowest index wins).
//  5. 300 codes of "0" after loading T
//       -> 300 sym_valid pulses; sym_cnt saturates at 255.
//     Then code_valid with bit_valid=1 in the same cycle -> sym_cnt=0, bit dropped, no pulse.
//  6. Bits 1,1 after loading T, then reset
//       -> all outputs at reset values, ready=0.
//     Bits 0,0 with no reload -> no sym_valid.
//  7. Table where every M=1F and no code has prefix 11100, MAX_LEN=5, bits 1,1,1,0,0
//       -> err=1 the cycle after the 5th bit; no sym_valid.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared definitions for the 6-symbol huffman decoder.
//   NUM_SYM  number of code table entries
//   W        width of code/mask entries, accumulator and symbol index
//   LEN_W    width of the code-length counter (holds lengths up to 15)
//   dec_state_e  decoder FSM encoding
//   len_mask(n)  mask with the n low bits set
//   is_mask(m)   1 when m is a legal code mask (code length 1..7)
package huffman_pkg;

  localparam int NUM_SYM = 6;
  localparam int W       = 8;
  localparam int LEN_W   = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERR   = 2'd2
  } dec_state_e;

  // Built bit by bit so that n == W does not overflow the shift.
  function automatic logic [W-1:0] len_mask(input logic [LEN_W-1:0] n);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  function automatic logic is_mask(input logic [W-1:0] m);
    logic ok;
    case (m)
      W'('h01), W'('h03), W'('h07), W'('h0F),
      W'('h1F), W'('h3F), W'('h7F): ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/huffman_code_match.sv
// Combinational match of the candidate prefix against one table entry.
//   hc_i    code of this symbol, right-aligned
//   m_i     mask of this symbol, (1<<len)-1
//   nacc_i  accumulator including the bit being received
//   nlen_i  number of bits in nacc_i
//   hit_o   1 when the prefix is exactly this symbol's code
module huffman_code_match #(
  parameter int W     = huffman_pkg::W,
  parameter int LEN_W = huffman_pkg::LEN_W
) (
  input  logic [W-1:0]     hc_i,
  input  logic [W-1:0]     m_i,
  input  logic [W-1:0]     nacc_i,
  input  logic [LEN_W-1:0] nlen_i,
  output logic             hit_o
);
  import huffman_pkg::*;

  // Length must match exactly; a shorter code never fires on a longer prefix.
  assign hit_o = (m_i == len_mask(nlen_i)) && ((nacc_i & m_i) == hc_i);

endmodule

// File: rtl/huffman_decoder.sv
// Serial MSB-first huffman decoder for a 6-entry code table.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   code_valid          1-cycle pulse loading HC1..6 / M1..6
//   HC1..HC6, M1..M6    code and mask of symbols 1..6
//   bit_valid, bit_data serial code bit, MSB first
//   ready               table loaded and decoding
//   sym_valid/sym_data  1-cycle pulse with the decoded symbol index 1..6
//   sym_cnt             symbols decoded since last load, saturating at 255
//   err                 sticky table/decode error
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | no table loaded; bits ignored
// ST_RUN   | decoding incoming bits
// ST_ERR   | bad table or undecodable prefix; bits ignored
//
// W must equal huffman_pkg::W (the package helpers are sized by it).
module huffman_decoder #(
  parameter int W       = huffman_pkg::W,
  parameter int MAX_LEN = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         code_valid,
  input  logic [W-1:0] HC1,
  input  logic [W-1:0] HC2,
  input  logic [W-1:0] HC3,
  input  logic [W-1:0] HC4,
  input  logic [W-1:0] HC5,
  input  logic [W-1:0] HC6,
  input  logic [W-1:0] M1,
  input  logic [W-1:0] M2,
  input  logic [W-1:0] M3,
  input  logic [W-1:0] M4,
  input  logic [W-1:0] M5,
  input  logic [W-1:0] M6,
  input  logic         bit_valid,
  input  logic         bit_data,
  output logic         ready,
  output logic         sym_valid,
  output logic [W-1:0] sym_data,
  output logic [7:0]   sym_cnt,
  output logic         err
);
  import huffman_pkg::*;

  logic [W-1:0]     hc_in [NUM_SYM];
  logic [W-1:0]     m_in  [NUM_SYM];
  logic [W-1:0]     hc_q  [NUM_SYM];
  logic [W-1:0]     m_q   [NUM_SYM];

  dec_state_e       state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             sv_q, sv_d;
  logic [W-1:0]     sd_q, sd_d;

  logic [W-1:0]     nacc;
  logic [LEN_W-1:0] nlen;
  logic [NUM_SYM-1:0] hit;
  logic             any_hit;
  logic [W-1:0]     hit_sym;
  logic             table_ok;

  assign hc_in[0] = HC1;
  assign hc_in[1] = HC2;
  assign hc_in[2] = HC3;
  assign hc_in[3] = HC4;
  assign hc_in[4] = HC5;
  assign hc_in[5] = HC6;
  assign m_in[0]  = M1;
  assign m_in[1]  = M2;
  assign m_in[2]  = M3;
  assign m_in[3]  = M4;
  assign m_in[4]  = M5;
  assign m_in[5]  = M6;

  assign nacc = {acc_q[W-2:0], bit_data};
  assign nlen = len_q + LEN_W'(1);

  for (genvar k = 0; k < NUM_SYM; k++) begin : g_match
    huffman_code_match #(
      .W     (W),
      .LEN_W (LEN_W)
    ) u_match (
      .hc_i   (hc_q[k]),
      .m_i    (m_q[k]),
      .nacc_i (nacc),
      .nlen_i (nlen),
      .hit_o  (hit[k])
    );
  end

  // Scan from the top down so the lowest index is the one left standing.
  always_comb begin
    any_hit = 1'b0;
    hit_sym = '0;
    for (int k = NUM_SYM - 1; k >= 0; k--) begin
      if (hit[k]) begin
        any_hit = 1'b1;
        hit_sym = W'(k + 1);
      end
    end
  end

  always_comb begin
    table_ok = 1'b1;
    for (int k = 0; k < NUM_SYM; k++) begin
      if (!is_mask(m_in[k])) table_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sv_d    = 1'b0;
    sd_d    = sd_q;

    if (code_valid) begin
      // A load overrides everything, including a bit arriving the same cycle.
      acc_d   = '0;
      len_d   = '0;
      cnt_d   = '0;
      state_d = table_ok ? ST_RUN : ST_ERR;
      err_d   = !table_ok;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bit_valid) begin
            if (any_hit) begin
              sv_d  = 1'b1;
              sd_d  = hit_sym;
              acc_d = '0;
              len_d = '0;
              if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end else begin
              acc_d = nacc;
              len_d = nlen;
              if (nlen == LEN_W'(MAX_LEN)) begin
                state_d = ST_ERR;
                err_d   = 1'b1;
              end
            end
          end
        end
        ST_EMPTY, ST_ERR: ;
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sv_q    <= 1'b0;
      sd_q    <= '0;
      for (int k = 0; k < NUM_SYM; k++) begin
        hc_q[k] <= '0;
        m_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sv_q    <= sv_d;
      sd_q    <= sd_d;
      if (code_valid) begin
        for (int k = 0; k < NUM_SYM; k++) begin
          hc_q[k] <= hc_in[k];
          m_q[k]  <= m_in[k];
        end
      end
    end
  end

  assign ready     = (state_q == ST_RUN);
  assign sym_valid = sv_q;
  assign sym_data  = sd_q;
  assign sym_cnt   = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_huffman_decoder.sv
module tb_huffman_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0] M1, M2, M3, M4, M5, M6;
  logic       bit_valid, bit_data;

  logic       ready, sym_valid, err;
  logic [7:0] sym_data, sym_cnt;
  logic       ready5, sym_valid5, err5;
  logic [7:0] sym_data5, sym_cnt5;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  huffman_decoder #(.W(8), .MAX_LEN(8)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
    .bit_valid(bit_valid), .bit_data(bit_data),
    .ready(ready), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_cnt(sym_cnt), .err(err)
  );

  huffman_decoder #(.W(8), .MAX_LEN(5)) dut5 (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
    .bit_valid(bit_valid), .bit_data(bit_data),
    .ready(ready5), .sym_valid(sym_valid5), .sym_data(sym_data5),
    .sym_cnt(sym_cnt5), .err(err5)
  );

  typedef struct {
    logic       bv;
    logic       bd;
    logic       exp_sv;
    logic [7:0] exp_sd;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  localparam logic [47:0] T_HC = 48'h00_02_06_0E_1E_1F;
  localparam logic [47:0] T_M  = 48'h01_03_07_0F_1F_1F;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tbl(input logic [47:0] hcs, input logic [47:0] ms, input logic bv);
    {HC1, HC2, HC3, HC4, HC5, HC6} = hcs;
    {M1, M2, M3, M4, M5, M6}       = ms;
    code_valid = 1'b1;
    bit_valid  = bv;
    bit_data   = 1'b0;
    tick();
    code_valid = 1'b0;
    bit_valid  = 1'b0;
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bit_valid = vecs[i].bv;
      bit_data  = vecs[i].bd;
      tick();
      chk($sformatf("vec%0d sym_valid", i), sym_valid, vecs[i].exp_sv);
      chk($sformatf("vec%0d sym_data", i), sym_data, vecs[i].exp_sd);
    end
    bit_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_data  = b;
    tick();
    bit_valid = 1'b0;
  endtask

  initial begin
    int pulses;

    // scenario 1: bits 0 10 11111 -> 1,2,6
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'd1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'd2};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'd2};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'd2};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'd2};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'd2};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'd6};
    // scenario 2: 1,1, five idle cycles, 0 -> 3
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'd6};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'd6};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'd6};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'd6};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'd6};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'd6};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'd6};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 8'd3};
    // scenario 4: duplicate code 11110 -> 5
    vecs[16] = '{1'b1, 1'b1, 1'b0, 8'd3};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 8'd3};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 8'd3};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 8'd3};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 8'd5};

    reset = 1'b1; code_valid = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
    {HC1, HC2, HC3, HC4, HC5, HC6} = '0;
    {M1, M2, M3, M4, M5, M6} = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst ready", ready, 1'b0);
    chk("rst sym_valid", sym_valid, 1'b0);
    chk("rst sym_data", sym_data, 8'd0);
    chk("rst sym_cnt", sym_cnt, 8'd0);
    chk("rst err", err, 1'b0);
    send_bit(1'b0);
    chk("empty ignores bit", sym_valid, 1'b0);

    // scenario 1
    load_tbl(T_HC, T_M, 1'b0);
    chk("s1 ready", ready, 1'b1);
    chk("s1 err", err, 1'b0);
    run_vecs(0, 7);
    tick();
    chk("s1 pulse width", sym_valid, 1'b0);
    chk("s1 sym_cnt", sym_cnt, 8'd3);
    chk("s1 ready end", ready, 1'b1);

    // scenario 2
    load_tbl(T_HC, T_M, 1'b0);
    chk("s2 cnt cleared", sym_cnt, 8'd0);
    run_vecs(8, 15);
    chk("s2 sym_cnt", sym_cnt, 8'd1);

    // scenario 3: bad mask
    load_tbl(T_HC, 48'h01_03_05_0F_1F_1F, 1'b0);
    chk("s3 ready", ready, 1'b0);
    chk("s3 err", err, 1'b1);
    send_bit(1'b0);
    chk("s3 no sym", sym_valid, 1'b0);
    send_bit(1'b0);
    chk("s3 no sym 2", sym_valid, 1'b0);
    chk("s3 err sticky", err, 1'b1);

    // scenario 4
    load_tbl(48'h00_02_06_0E_1E_1E, T_M, 1'b0);
    chk("s4 err cleared", err, 1'b0);
    chk("s4 ready", ready, 1'b1);
    run_vecs(16, 20);

    // scenario 5: 300 one-bit codes, counter saturates
    load_tbl(T_HC, T_M, 1'b0);
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      bit_valid = 1'b1;
      bit_data  = 1'b0;
      tick();
      if (sym_valid === 1'b1) pulses++;
      if (i == 253) chk("s5 cnt 254", sym_cnt, 8'd254);
    end
    bit_valid = 1'b0;
    chk("s5 pulses", pulses, 300);
    chk("s5 sym_cnt sat", sym_cnt, 8'd255);
    load_tbl(T_HC, T_M, 1'b1);
    chk("s5 load cnt", sym_cnt, 8'd0);
    chk("s5 load no pulse", sym_valid, 1'b0);
    tick();
    chk("s5 dropped bit", sym_valid, 1'b0);
    chk("s5 cnt stays 0", sym_cnt, 8'd0);

    // scenario 6: reset mid-code drops the table
    load_tbl(T_HC, T_M, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6 ready", ready, 1'b0);
    chk("s6 sym_valid", sym_valid, 1'b0);
    chk("s6 sym_data", sym_data, 8'd0);
    chk("s6 sym_cnt", sym_cnt, 8'd0);
    chk("s6 err", err, 1'b0);
    send_bit(1'b0);
    chk("s6 no sym a", sym_valid, 1'b0);
    send_bit(1'b0);
    chk("s6 no sym b", sym_valid, 1'b0);
    chk("s6 ready after", ready, 1'b0);

    // scenario 7: MAX_LEN=5 instance, prefix 11100 matches nothing
    load_tbl(48'h00_01_02_03_04_05, 48'h1F_1F_1F_1F_1F_1F, 1'b0);
    chk("s7 ready", ready5, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("s7 err before", err5, 1'b0);
    chk("s7 no sym before", sym_valid5, 1'b0);
    send_bit(1'b0);
    chk("s7 err", err5, 1'b1);
    chk("s7 no sym", sym_valid5, 1'b0);
    chk("s7 ready", ready5, 1'b0);
    chk("s7 cnt", sym_cnt5, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
